// File: rtl/riscv_sb_pkg.sv
// riscv_sb_pkg: shared constants and helpers for the N-wide scoreboard.
//   FU class codes, bypass-select code helpers, clog2 helpers.
package riscv_sb_pkg;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_LS  = 2'd1;
    localparam logic [1:0] FU_MD  = 2'd2;  // 2'd3 is reserved and behaves as MD

    // Bypass select 0 means "read the architectural register file".
    localparam int BYP_RF = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width for an index that must be at least one bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // Select code for a result sitting in stage `stage` of lane `lane`.
    function automatic int byp_code(input int lane, input int stage, input int depth);
        return 1 + lane * depth + stage;
    endfunction

    // Select code for a result that has left the pipeline and lives in the ROB.
    function automatic int byp_rob(input int issue_w, input int depth);
        return issue_w * depth + 1;
    endfunction

endpackage

// File: rtl/riscv_sb_entry.sv
// riscv_sb_entry: state for one ROB tag.
//   clk, reset      : clock, async active-high reset
//   iss_hit/lane/fu : winning issue to this tag (already lane-prioritised)
//   cmt_hit         : some commit port names this tag
//   flush           : squash tracking
//   stall           : full per-lane, per-stage hold matrix
//   pend/lane/fu/pos: registered state; pos is one-hot stage or zero
//   ready           : operand-ready bit for this tag
module riscv_sb_entry
    import riscv_sb_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 5,
    parameter int LW      = 1,
    parameter int RDY_ALU = 0,
    parameter int RDY_LS  = 1,
    parameter int RDY_MD  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           iss_hit,
    input  logic [LW-1:0]                  iss_lane,
    input  logic [1:0]                     iss_fu,
    input  logic                           cmt_hit,
    input  logic                           flush,
    input  logic [ISSUE_W-1:0][DEPTH-1:0]  stall,
    output logic                           pend,
    output logic [LW-1:0]                  lane,
    output logic [1:0]                     fu,
    output logic [DEPTH-1:0]               pos,
    output logic                           ready
);

    logic [DEPTH-1:0] row;
    logic [DEPTH-1:0] pos_adv;
    logic             stage_ok;
    int               thr;

    // Held bit stays put; free bit shifts up. Shifting out of W leaves pos=0.
    always_comb begin
        row     = stall[lane];
        pos_adv = (pos & row) | ((pos & ~row) << 1);
    end

    always_comb begin
        case (fu)
            FU_ALU:  thr = RDY_ALU;
            FU_LS:   thr = RDY_LS;
            default: thr = RDY_MD;
        endcase
        stage_ok = 1'b0;
        for (int s = 0; s < DEPTH; s++)
            if (pos[s] && s >= thr) stage_ok = 1'b1;
        ready = !pend || (pos == '0) || stage_ok;
    end

    // Priority: flush > issue > (advance, commit). Issue beats a same-cycle commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            lane <= '0;
            fu   <= '0;
            pos  <= '0;
        end else if (flush) begin
            pend <= 1'b0;
            pos  <= '0;
        end else if (iss_hit) begin
            pend <= 1'b1;
            lane <= iss_lane;
            fu   <= iss_fu;
            pos  <= DEPTH'(1);
        end else begin
            pos <= pos_adv;
            if (cmt_hit) pend <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_core_scoreboard_nw.sv
// riscv_core_scoreboard_nw: N-wide result scoreboard with bypass selects.
//   clk, reset          : clock, async active-high reset
//   iss_val/wen/tag/fu  : per-lane issue of a destination tag
//   stall               : per-lane, per-stage hold
//   src_tag/src_ren     : two sources per lane
//   cmt_val/cmt_tag     : ROB commit ports
//   flush               : squash all tracking
//   byp_sel             : per-source bypass select (0 RF, 1+lane*DEPTH+s, ROB code)
//   src_ready           : per-tag operand ready
module riscv_core_scoreboard_nw
    import riscv_sb_pkg::*;
#(
    parameter int NUM_TAGS = 32,
    parameter int ISSUE_W  = 2,
    parameter int DEPTH    = 5,
    parameter int COMMIT_W = 2,
    parameter int RDY_ALU  = 0,
    parameter int RDY_LS   = 1,
    parameter int RDY_MD   = 3,
    // Derived widths; leave at default.
    parameter int TW = clog2_min1(NUM_TAGS),
    parameter int LW = clog2_min1(ISSUE_W),
    parameter int SW = clog2(ISSUE_W * DEPTH + 2)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ISSUE_W-1:0]                   iss_val,
    input  logic [ISSUE_W-1:0]                   iss_wen,
    input  logic [ISSUE_W-1:0][TW-1:0]           iss_tag,
    input  logic [ISSUE_W-1:0][1:0]              iss_fu,
    input  logic [ISSUE_W-1:0][DEPTH-1:0]        stall,
    input  logic [ISSUE_W-1:0][1:0][TW-1:0]      src_tag,
    input  logic [ISSUE_W-1:0][1:0]              src_ren,
    input  logic [COMMIT_W-1:0]                  cmt_val,
    input  logic [COMMIT_W-1:0][TW-1:0]          cmt_tag,
    input  logic                                 flush,
    output logic [ISSUE_W-1:0][1:0][SW-1:0]      byp_sel,
    output logic [NUM_TAGS-1:0]                  src_ready
);

    logic [NUM_TAGS-1:0]            hit;
    logic [NUM_TAGS-1:0][LW-1:0]    hit_lane;
    logic [NUM_TAGS-1:0][1:0]       hit_fu;
    logic [NUM_TAGS-1:0]            cmt_hit;
    logic [NUM_TAGS-1:0]            pend_v;
    logic [NUM_TAGS-1:0][LW-1:0]    lane_v;
    logic [NUM_TAGS-1:0][1:0]       fu_v;
    logic [NUM_TAGS-1:0][DEPTH-1:0] pos_v;
    logic [TW-1:0]                  t;

    // Scan lanes high to low so the lowest matching lane is the last writer.
    always_comb begin
        hit      = '0;
        hit_lane = '0;
        hit_fu   = '0;
        cmt_hit  = '0;
        for (int k = 0; k < NUM_TAGS; k++) begin
            for (int l = ISSUE_W - 1; l >= 0; l--) begin
                if (iss_val[l] && iss_wen[l] && iss_tag[l] == TW'(k)) begin
                    hit[k]      = 1'b1;
                    hit_lane[k] = LW'(l);
                    hit_fu[k]   = iss_fu[l];
                end
            end
            for (int c = 0; c < COMMIT_W; c++)
                if (cmt_val[c] && cmt_tag[c] == TW'(k)) cmt_hit[k] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_ent
        riscv_sb_entry #(
            .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .LW(LW),
            .RDY_ALU(RDY_ALU), .RDY_LS(RDY_LS), .RDY_MD(RDY_MD)
        ) u_ent (
            .clk      (clk),
            .reset    (reset),
            .iss_hit  (hit[g]),
            .iss_lane (hit_lane[g]),
            .iss_fu   (hit_fu[g]),
            .cmt_hit  (cmt_hit[g]),
            .flush    (flush),
            .stall    (stall),
            .pend     (pend_v[g]),
            .lane     (lane_v[g]),
            .fu       (fu_v[g]),
            .pos      (pos_v[g]),
            .ready    (src_ready[g])
        );
    end

    // Bypass selects look only at registered state.
    always_comb begin
        byp_sel = '0;
        t       = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            for (int j = 0; j < 2; j++) begin
                t = src_tag[l][j];
                byp_sel[l][j] = SW'(BYP_RF);
                if (src_ren[l][j] && pend_v[t]) begin
                    if (pos_v[t] == '0)
                        byp_sel[l][j] = SW'(byp_rob(ISSUE_W, DEPTH));
                    else
                        for (int s = 0; s < DEPTH; s++)
                            if (pos_v[t][s])
                                byp_sel[l][j] = SW'(byp_code(int'(lane_v[t]), s, DEPTH));
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_scoreboard_nw.sv
module tb_riscv_core_scoreboard_nw;

    localparam int NT = 32, IW = 2, D = 5, CW = 2, TW = 5, SW = 4;
    localparam int ROB = IW * D + 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [IW-1:0]             iss_val, iss_wen;
    logic [IW-1:0][TW-1:0]     iss_tag;
    logic [IW-1:0][1:0]        iss_fu;
    logic [IW-1:0][D-1:0]      stall;
    logic [IW-1:0][1:0][TW-1:0] src_tag;
    logic [IW-1:0][1:0]        src_ren;
    logic [CW-1:0]             cmt_val;
    logic [CW-1:0][TW-1:0]     cmt_tag;
    logic                      flush;
    logic [IW-1:0][1:0][SW-1:0] byp_sel;
    logic [NT-1:0]             src_ready;

    riscv_core_scoreboard_nw dut (
        .clk(clk), .reset(reset), .iss_val(iss_val), .iss_wen(iss_wen),
        .iss_tag(iss_tag), .iss_fu(iss_fu), .stall(stall), .src_tag(src_tag),
        .src_ren(src_ren), .cmt_val(cmt_val), .cmt_tag(cmt_tag), .flush(flush),
        .byp_sel(byp_sel), .src_ready(src_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference state: pos is a stage number, -1 when the value is in the ROB.
    int m_pend[NT], m_lane[NT], m_fu[NT], m_pos[NT];
    int md_exp[6] = '{6, 7, 7, 7, 8, 9};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_pend[t] = 0; m_lane[t] = 0; m_fu[t] = 0; m_pos[t] = -1;
        end
    endtask

    function automatic int exp_byp(input int l, input int j);
        int t;
        t = int'(src_tag[l][j]);
        if (!src_ren[l][j] || !m_pend[t]) return 0;
        if (m_pos[t] < 0) return ROB;
        return 1 + m_lane[t] * D + m_pos[t];
    endfunction

    function automatic logic [NT-1:0] exp_rdy();
        logic [NT-1:0] r;
        int thr;
        for (int t = 0; t < NT; t++) begin
            thr = (m_fu[t] == 0) ? 0 : (m_fu[t] == 1) ? 1 : 3;
            r[t] = !m_pend[t] || m_pos[t] < 0 || m_pos[t] >= thr;
        end
        return r;
    endfunction

    task automatic model_update();
        int win;
        bit cm;
        if (flush) begin
            for (int t = 0; t < NT; t++) begin m_pend[t] = 0; m_pos[t] = -1; end
            return;
        end
        for (int t = 0; t < NT; t++) begin
            win = -1;
            for (int l = 0; l < IW; l++)
                if (win < 0 && iss_val[l] && iss_wen[l] && int'(iss_tag[l]) == t) win = l;
            cm = 0;
            for (int c = 0; c < CW; c++)
                if (cmt_val[c] && int'(cmt_tag[c]) == t) cm = 1;
            if (win >= 0) begin
                m_pend[t] = 1; m_lane[t] = win; m_fu[t] = int'(iss_fu[win]); m_pos[t] = 0;
            end else begin
                if (m_pos[t] >= 0 && !stall[m_lane[t]][m_pos[t]])
                    m_pos[t] = (m_pos[t] == D - 1) ? -1 : m_pos[t] + 1;
                if (cm) m_pend[t] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int l = 0; l < IW; l++)
            for (int j = 0; j < 2; j++)
                chk("model_byp", byp_sel[l][j], exp_byp(l, j));
        chk("model_rdy", src_ready, exp_rdy());
    endtask

    task automatic idle();
        iss_val = '0; iss_wen = '0; iss_tag = '0; iss_fu = '0; stall = '0;
        src_tag = '0; src_ren = '0; cmt_val = '0; cmt_tag = '0; flush = 1'b0;
    endtask

    // Called at negedge with inputs set: compare, clock once, return at negedge.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset_check();
        reset = 1'b1;
        #1;
        chk("rst_ready", src_ready, {NT{1'b1}});
        chk("rst_byp", byp_sel, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1 chk("reset_ready", src_ready, {NT{1'b1}});
        chk("reset_byp", byp_sel, '0);

        // Lane 0, tag 5, ALU, no stalls
        idle(); iss_val = 2'b01; iss_wen = 2'b01; iss_tag[0] = 5'd5; iss_fu[0] = 2'd0;
        step();
        idle(); src_ren[0][0] = 1'b1; src_tag[0][0] = 5'd5;
        for (int k = 0; k < 5; k++) begin
            #1 chk("alu_walk", byp_sel[0][0], 64'(k + 1));
            step();
        end
        #1 chk("alu_rob", byp_sel[0][0], 64'd11);
        chk("alu_rdy", src_ready[5], 1'b1);
        cmt_val = 2'b01; cmt_tag[0] = 5'd5;
        step();
        cmt_val = '0;
        #1 chk("alu_commit", byp_sel[0][0], 64'd0);
        step();

        // Lane 1, tag 9, MD, stage 1 held two cycles
        idle(); iss_val = 2'b10; iss_wen = 2'b10; iss_tag[1] = 5'd9; iss_fu[1] = 2'd2;
        step();
        idle(); src_ren[1][0] = 1'b1; src_tag[1][0] = 5'd9;
        for (int k = 0; k < 6; k++) begin
            #1 chk("md_byp", byp_sel[1][0], 64'(md_exp[k]));
            chk("md_rdy", src_ready[9], (k == 5) ? 1'b1 : 1'b0);
            stall[1][1] = (k == 1 || k == 2);
            step();
        end

        // Both lanes issue tag 3; then issue and commit tag 4 together
        idle(); iss_val = 2'b11; iss_wen = 2'b11; iss_tag[0] = 5'd3; iss_tag[1] = 5'd3;
        iss_fu[0] = 2'd0; iss_fu[1] = 2'd2;
        step();
        idle(); src_ren[0][0] = 1'b1; src_tag[0][0] = 5'd3;
        #1 chk("dup_lane0", byp_sel[0][0], 64'd1);
        chk("dup_fu_alu", src_ready[3], 1'b1);
        iss_val = 2'b01; iss_wen = 2'b01; iss_tag[0] = 5'd4; iss_fu[0] = 2'd2;
        cmt_val = 2'b01; cmt_tag[0] = 5'd4;
        step();
        idle(); src_ren[0][1] = 1'b1; src_tag[0][1] = 5'd4;
        #1 chk("iss_beats_cmt", byp_sel[0][1], 64'd1);
        step();

        // Six tags pending, then flush with a simultaneous issue of tag 7
        for (int k = 0; k < 3; k++) begin
            idle(); iss_val = 2'b11; iss_wen = 2'b11; iss_fu = {2'd2, 2'd2};
            iss_tag[0] = 5'(10 + 2 * k); iss_tag[1] = 5'(11 + 2 * k);
            step();
        end
        idle();
        #1 chk("pre_flush_rdy", src_ready[10], 1'b0);
        flush = 1'b1; iss_val = 2'b01; iss_wen = 2'b01; iss_tag[0] = 5'd7; iss_fu[0] = 2'd2;
        step();
        idle(); src_ren[0][0] = 1'b1; src_tag[0][0] = 5'd7;
        #1 chk("flush_rdy", src_ready, {NT{1'b1}});
        chk("flush_tag7", byp_sel[0][0], 64'd0);
        step();

        // Unrenamed source on a pending LS tag; LS readiness at X0 / X1
        idle(); iss_val = 2'b01; iss_wen = 2'b01; iss_tag[0] = 5'd20; iss_fu[0] = 2'd1;
        step();
        idle(); src_tag[0][0] = 5'd20;
        #1 chk("ren0_byp", byp_sel[0][0], 64'd0);
        chk("ls_x0_rdy", src_ready[20], 1'b0);
        step();
        #1 chk("ls_x1_rdy", src_ready[20], 1'b1);
        src_ren[0][0] = 1'b1;
        #1 chk("ls_x1_byp", byp_sel[0][0], 64'd2);

        // Reset mid-run with tag 20 pending
        do_reset_check();
        #1 chk("post_rst_ready", src_ready, {NT{1'b1}});
        chk("post_rst_byp", byp_sel[0][0], 64'd0);
        step();

        // Randomised traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iss_val = 2'($urandom); iss_wen = 2'($urandom);
            for (int l = 0; l < IW; l++) begin
                iss_tag[l] = 5'($urandom_range(0, 15));
                iss_fu[l]  = 2'($urandom);
                for (int s = 0; s < D; s++) stall[l][s] = ($urandom_range(0, 5) == 0);
                for (int j = 0; j < 2; j++) begin
                    src_tag[l][j] = 5'($urandom_range(0, 15));
                    src_ren[l][j] = 1'($urandom);
                end
            end
            for (int c = 0; c < CW; c++) begin
                cmt_val[c] = ($urandom_range(0, 2) == 0);
                cmt_tag[c] = 5'($urandom_range(0, 15));
            end
            flush = ($urandom_range(0, 99) == 0);
            if (cyc == 1500) do_reset_check();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_core_scoreboard_nw.md
Name: riscv_core_scoreboard_nw

Overview:
Parametrised N-wide scoreboard for the out-of-order issue cores. It tracks, per ROB tag, whether a result is pending, which issue lane produced it, and its one-hot position in that lane's X0..Xn/W pipeline. From that state it produces per-source bypass selects and a per-tag src_ready vector for the issue queue. It generalises the fixed 2-wide scoreboard to any lane count, depth and commit width, and adds global flush, per-FU ready stages and defined same-cycle priorities.

Parameters:
NUM_TAGS, 32, number of ROB tags tracked; TW = clog2(NUM_TAGS).
ISSUE_W, 2, number of issue lanes; each lane has 2 sources.
DEPTH, 5, stages per lane, X0..X(DEPTH-2) then W; stage index 0 = X0.
COMMIT_W, 2, ROB commit ports.
RDY_ALU, 0, first stage index at which an ALU result counts as ready.
RDY_LS, 1, same, for load/store.
RDY_MD, 3, same, for mul/div.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
iss_val  in  ISSUE_W  lane issues this cycle.
iss_wen  in  ISSUE_W  issued instruction writes a destination tag.
iss_tag  in  ISSUE_W*TW  destination ROB tag per lane.
iss_fu  in  ISSUE_W*2  FU class per lane: 0 ALU, 1 LS, 2 MD, 3 reserved (treated as MD).
stall  in  ISSUE_W*DEPTH  per-lane, per-stage hold; bit L*DEPTH+s holds stage s of lane L.
src_tag  in  ISSUE_W*2*TW  source tags; source j of lane L at index L*2+j.
src_ren  in  ISSUE_W*2  source is renamed (reads a ROB tag, not the architectural file).
cmt_val  in  COMMIT_W  commit port valid.
cmt_tag  in  COMMIT_W*TW  committed tag.
flush  in  1  squash all in-flight tracking.
byp_sel  out  ISSUE_W*2*SW  bypass select per source; SW = clog2(ISSUE_W*DEPTH+2).
src_ready  out  NUM_TAGS  per-tag operand-ready.

Behaviour:
- Per-tag state: pend (1b), lane (clog2 ISSUE_W), fu (2b), pos (DEPTH-bit one-hot or zero).
- Reset (async): all pend=0, pos=0, lane=0, fu=0. This gives src_ready all-ones and byp_sel all zero.
- Issue: if iss_val[L] and iss_wen[L], then tag iss_tag[L] gets pend=1, lane=L, fu=iss_fu[L], pos=bit0 (X0) at the next edge.
- Same tag from two lanes in one cycle: the lowest lane wins (an illegal upstream condition, but deterministic).
- Advance, for each tag not being issued this cycle:
  - Bit s moves to s+1 unless stall[lane*DEPTH+s].
  - Bit DEPTH-1 (W) clears to pos=0 unless stalled.
  - pos=0 with pend=1 means the value sits in the ROB.
- Commit: a tag matching any valid cmt_tag gets pend=0 at the next edge.
- Issue to a tag beats a commit of the same tag in the same cycle.
- Flush: at the next edge, all pend=0 and pos=0. Issue and commit in the same cycle are ignored. Flush has priority over everything except reset.
- byp_sel, per source, combinational from registered state only (no same-cycle issue forwarding; intra-bundle dependences are resolved upstream):
  - 0 if src_ren=0 or pend=0.
  - 1 + lane*DEPTH + s if pos bit s is set.
  - ISSUE_W*DEPTH+1 (ROB code) if pend=1 and pos=0.
- src_ready[i] = 1 if pend=0, or pos=0, or the index of the set pos bit >= RDY_<fu>.
- Widths: all index arithmetic is unsigned at SW bits; no wrap is possible by construction.
- Reset mid-operation clears state immediately; outputs reflect reset state within the same cycle.

Decomposition:
- Package riscv_sb_pkg holds:
  - FU class constants (FU_ALU/FU_LS/FU_MD).
  - BYP_RF=0.
  - Functions byp_code(lane, stage) and byp_rob().
  - clog2 helpers.
- Sub-module riscv_sb_entry: one tag's state, with issue/advance/commit/flush priority and its src_ready bit. Instantiate it NUM_TAGS times via generate.
- The top level holds the issue-select and commit-match decode, plus the per-source bypass muxes.

Test Plan:
- Reset mid-run with tags pending -> same cycle, src_ready=all 1 and byp_sel all 0; state stays clear after deassert.
- Defaults. Lane0 issues tag 5, ALU, no stalls; a source reads tag 5 renamed -> byp_sel = 1, 2, 3, 4, 5 over 5 cycles, then 11 (ROB); commit tag 5 -> 0 next cycle.
- Lane1 issues tag 9, MD, with stall[1*5+1] high for 2 cycles -> byp_sel 6, 7, 7, 7, 8, then continues. src_ready[9]=0 until pos reaches stage 3 (byp 9).
- Lanes 0 and 1 both issue tag 3 -> lane=0 recorded, byp_sel=1. Same cycle, issue tag 4 while committing tag 4 -> tag 4 stays pending.
- Flush with 6 tags pending plus a simultaneous issue of tag 7 -> next cycle all pend=0, src_ready all 1, tag 7 not pending.
- Source with src_ren=0 on a pending tag -> byp_sel=0. A LS tag at X0 -> src_ready=0; at X1 -> 1.
